// File: rtl/tcp_vlg_tx_seg.sv
// tcp_vlg_tx_seg
//   Segmenter sitting after the TCP TX byte buffer. It keeps nxt, the sequence
//   number of the next byte to transmit. It reads unsent bytes through the
//   buffer's registered random-read port. It streams them to the packet
//   assembler as contiguous segments of at most MSS bytes. When no ack progress
//   is seen for RTO_TICKS cycles, it rewinds nxt to the remote ack.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   en            connection established; low holds idle with nxt tracking ack
//   seq           one past the last byte written into the buffer
//   ack           latest remote ack number
//   buf_addr      buffer read address (low D bits of the sequence number)
//   buf_data      buffer read data, valid one cycle after buf_addr
//   out_rdy       assembler idle, sampled only when a segment is about to start
//   out_val       payload byte valid
//   out_dat       payload byte (the buffer data passes straight through)
//   out_sof       first byte of segment
//   out_eof       last byte of segment
//   out_seq       sequence number of the first byte, held for the whole segment
//   out_len       byte count of the segment, held for the whole segment
//   retrans       one-cycle pulse when nxt is rewound to ack
module tcp_vlg_tx_seg #(
    parameter int D           = 16,
    parameter int MSS         = 1460,
    parameter int FLUSH_TICKS = 1250,
    parameter int RTO_TICKS   = 125000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [31:0]  seq,
    input  logic [31:0]  ack,
    output logic [D-1:0] buf_addr,
    input  logic [7:0]   buf_data,
    input  logic         out_rdy,
    output logic         out_val,
    output logic [7:0]   out_dat,
    output logic         out_sof,
    output logic         out_eof,
    output logic [31:0]  out_seq,
    output logic [15:0]  out_len,
    output logic         retrans
);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    // Counter widths keep one spare value so a tick count of 0 still yields a
    // legal width.
    localparam int FW = $clog2(FLUSH_TICKS + 2);
    localparam int RW = $clog2(RTO_TICKS + 2);

    localparam logic [31:0]   MSS32     = 32'(MSS);
    localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_TICKS);
    localparam logic [RW-1:0] RTO_MAX   = RW'(RTO_TICKS);

    state_t        state;
    logic [31:0]   nxt;
    logic [31:0]   ack_q;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] rto_cnt;
    logic [15:0]   byte_cnt;

    logic [31:0]   pending;
    logic [31:0]   unacked;
    logic [31:0]   ack_ahead;
    logic [15:0]   seg_len;
    logic          rto_expired;
    logic [RW-1:0] rto_next;

    assign pending     = seq - nxt;
    assign unacked     = nxt - ack;
    assign ack_ahead   = ack - nxt;
    assign seg_len     = (pending >= MSS32) ? MSS32[15:0] : pending[15:0];
    assign rto_expired = (rto_cnt >= RTO_MAX);
    assign out_dat     = buf_data;

    // The timer runs in every state. It saturates, so an expiry that lands
    // inside a segment is still seen once the FSM is back in IDLE.
    assign rto_next = (unacked == 32'd0 || ack != ack_q) ? '0 :
                      (rto_expired ? rto_cnt : rto_cnt + RW'(1));

    // NOTE: every register here uses non-blocking assignment. That way each
    // branch reads the pre-edge values of nxt, counters and outputs, no matter
    // what order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            nxt       <= '0;
            ack_q     <= '0;
            flush_cnt <= '0;
            rto_cnt   <= '0;
            byte_cnt  <= '0;
            buf_addr  <= '0;
            out_val   <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_seq   <= '0;
            out_len   <= '0;
            retrans   <= 1'b0;
        end else if (!en) begin
            // Disconnected, or an abort in the middle of a segment. Drop
            // everything and let nxt follow the peer.
            state     <= IDLE;
            nxt       <= ack;
            ack_q     <= ack;
            flush_cnt <= '0;
            rto_cnt   <= '0;
            byte_cnt  <= '0;
            out_val   <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            retrans   <= 1'b0;
        end else begin
            ack_q   <= ack;
            retrans <= 1'b0;
            rto_cnt <= rto_next;

            case (state)
                IDLE: begin
                    if (rto_expired) begin
                        // The rewind wins over a segment start in the same cycle.
                        nxt       <= ack;
                        retrans   <= 1'b1;
                        rto_cnt   <= '0;
                        flush_cnt <= '0;
                    end else if (ack_ahead != 32'd0 && !ack_ahead[31]) begin
                        // The peer acked beyond nxt (e.g. after a rewind). Skip
                        // the bytes it already has.
                        nxt       <= ack;
                        flush_cnt <= '0;
                    end else if (out_rdy && pending != 32'd0 &&
                                 (pending >= MSS32 || flush_cnt == FLUSH_MAX)) begin
                        out_len   <= seg_len;
                        out_seq   <= nxt;
                        buf_addr  <= nxt[D-1:0];
                        flush_cnt <= '0;
                        state     <= READ;
                    end else if (pending == 32'd0) begin
                        flush_cnt <= '0;
                    end else if (pending < MSS32 && flush_cnt != FLUSH_MAX) begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end

                READ: begin
                    // The buffer now returns the first byte. Present it next
                    // cycle and request the following address.
                    buf_addr <= buf_addr + D'(1);
                    out_val  <= 1'b1;
                    out_sof  <= 1'b1;
                    out_eof  <= (out_len == 16'd1);
                    byte_cnt <= 16'd1;
                    state    <= SEND;
                end

                SEND: begin
                    buf_addr <= buf_addr + D'(1);
                    out_sof  <= 1'b0;
                    if (byte_cnt == out_len) begin
                        out_val <= 1'b0;
                        out_eof <= 1'b0;
                        nxt     <= out_seq + {16'd0, out_len};
                        state   <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 16'd1;
                        out_eof  <= (byte_cnt + 16'd1 == out_len);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_vlg_tx_seg.sv
// Bench for tcp_vlg_tx_seg. The bench owns the TX byte buffer, which has a
// registered read port. A negedge monitor keeps a scoreboard from the transfer
// rules. The next expected segment starts at the model's nxt and carries
// min(seq - nxt, MSS) bytes, and its contents come from the bench's own copy
// of the buffer.
module tb_tcp_vlg_tx_seg;

    localparam int D   = 8;
    localparam int MSS = 16;
    localparam int FT  = 20;
    localparam int RT  = 200;

    logic         clk;
    logic         rst;
    logic         en;
    logic [31:0]  seq;
    logic [31:0]  ack;
    logic [D-1:0] buf_addr;
    logic [7:0]   buf_data;
    logic         out_rdy;
    logic         out_val;
    logic [7:0]   out_dat;
    logic         out_sof;
    logic         out_eof;
    logic [31:0]  out_seq;
    logic [15:0]  out_len;
    logic         retrans;

    tcp_vlg_tx_seg #(.D(D), .MSS(MSS), .FLUSH_TICKS(FT), .RTO_TICKS(RT)) dut (
        .clk(clk), .rst(rst), .en(en), .seq(seq), .ack(ack),
        .buf_addr(buf_addr), .buf_data(buf_data), .out_rdy(out_rdy),
        .out_val(out_val), .out_dat(out_dat), .out_sof(out_sof), .out_eof(out_eof),
        .out_seq(out_seq), .out_len(out_len), .retrans(retrans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<D)-1];
    always @(posedge clk) buf_data <= mem[buf_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    // Scoreboard state
    logic [31:0] model_nxt = '0;
    logic [31:0] seg_seq   = '0;
    logic [15:0] seg_len   = '0;
    int          idx       = 0;
    bit          in_seg    = 0;
    int          n_retrans = 0;
    int          retrans_cyc = 0;
    logic [31:0] log_seq[$];
    int          log_len[$];
    int          log_sof[$];
    int          log_eof[$];

    always @(negedge clk) begin
        logic [7:0] exp_byte;
        if (rst || !en) begin
            in_seg    = 0;
            model_nxt = ack;
        end else begin
            if (retrans) begin
                check("retrans_outside_seg", in_seg, 0);
                model_nxt   = ack;
                n_retrans++;
                retrans_cyc = cyc;
            end
            if (out_val) begin
                if (out_sof) begin
                    check("sof_not_in_seg", in_seg, 0);
                    check("sof_seq", out_seq, model_nxt);
                    check("sof_len", {16'd0, out_len}, min32(seq - model_nxt, 32'(MSS)));
                    in_seg  = 1;
                    seg_seq = out_seq;
                    seg_len = out_len;
                    idx     = 0;
                    log_sof.push_back(cyc);
                end else begin
                    check("byte_in_seg", in_seg, 1);
                    check("seq_held", out_seq, seg_seq);
                    check("len_held", {16'd0, out_len}, {16'd0, seg_len});
                end
                exp_byte = mem[D'(seg_seq + 32'(idx))];
                check("data", out_dat, exp_byte);
                idx++;
                check("eof_pos", out_eof, (idx == int'(seg_len)));
                if (out_eof) begin
                    in_seg    = 0;
                    model_nxt = seg_seq + {16'd0, seg_len};
                    log_seq.push_back(seg_seq);
                    log_len.push_back(int'(seg_len));
                    log_eof.push_back(cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_burst(input int n);
        for (int i = 0; i < n; i++) begin
            logic [D-1:0] a;
            a = D'(seq + 32'(i));
            mem[a] = 8'($urandom);
        end
        seq = seq + 32'(n);
    endtask

    task automatic clear_log();
        log_seq.delete();
        log_len.delete();
        log_sof.delete();
        log_eof.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        while ((model_nxt != seq || in_seg) && c < budget) begin
            tick(1);
            c++;
        end
        check(tag, (c < budget), 1);
    endtask

    task automatic rebase(input logic [31:0] base);
        en  = 1'b0;
        seq = base;
        ack = base;
        tick(2);
        en  = 1'b1;
        tick(1);
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] s0;
        logic [7:0]  b0;

        for (int i = 0; i < (1 << D); i++) mem[i] = 8'h00;
        rst = 1'b1; en = 1'b0; seq = '0; ack = '0; out_rdy = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_out_val", out_val, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_retrans", retrans, 0);
        check("rst_out_seq", out_seq, 0);
        check("rst_out_len", {16'd0, out_len}, 0);
        check("rst_buf_addr", {24'd0, buf_addr}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_rdy = 1'b1;
        rebase(32'h0000_1000);

        // 1: 40 bytes -> 16, 16, then an 8-byte flush
        clear_log();
        write_burst(40);
        wait_drain("t1_drain", 400);
        check("t1_nsegs", log_seq.size(), 3);
        if (log_seq.size() == 3) begin
            check("t1_seq0", log_seq[0], 32'h1000);
            check("t1_seq1", log_seq[1], 32'h1010);
            check("t1_seq2", log_seq[2], 32'h1020);
            check("t1_len0", log_len[0], 16);
            check("t1_len1", log_len[1], 16);
            check("t1_len2", log_len[2], 8);
            check("t1_flush_gap", log_sof[2] - log_eof[1], FT + 3);
        end
        ack = seq;
        tick(2);

        // 2: single byte flushed after FT idle cycles, sof and eof together
        clear_log();
        b0 = 8'($urandom);
        mem[D'(seq)] = b0;
        seq = seq + 32'd1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_val && n < FT + 50);
        check("t2_latency", n, FT + 2);
        check("t2_sof", out_sof, 1);
        check("t2_eof", out_eof, 1);
        check("t2_len", {16'd0, out_len}, 1);
        check("t2_dat", out_dat, b0);
        @(posedge clk); #1;
        wait_drain("t2_drain", 100);
        ack = seq;
        tick(2);

        // 3: ack held -> RTO rewind and identical resend
        clear_log();
        write_burst(10);
        wait_drain("t3_drain", 200);
        n = 0;
        while (n_retrans == 0 && n < RT + 50) begin
            tick(1);
            n++;
        end
        check("t3_retrans_seen", n_retrans, 1);
        if (log_eof.size() == 1) check("t3_rto_delay", retrans_cyc - log_eof[0], RT + 2);
        wait_drain("t3_redrain", 200);
        check("t3_nsegs", log_seq.size(), 2);
        if (log_seq.size() == 2) begin
            check("t3_same_seq", log_seq[1], log_seq[0]);
            check("t3_len", log_len[1], 10);
        end
        ack = seq;
        tick(2);

        // 4: sequence wrap near 2^32
        rebase(32'hFFFF_FFF0);
        clear_log();
        write_burst(48);
        wait_drain("t4_drain", 300);
        write_burst(1);
        ack = 32'h0000_0020;
        wait_drain("t4_drain2", 100);
        check("t4_nsegs", log_seq.size(), 4);
        if (log_seq.size() == 4) begin
            check("t4_seq0", log_seq[0], 32'hFFFF_FFF0);
            check("t4_seq1", log_seq[1], 32'h0000_0000);
            check("t4_seq2", log_seq[2], 32'h0000_0010);
            check("t4_nxt_end", log_seq[3], 32'h0000_0020);
            check("t4_len0", log_len[0], 16);
        end
        ack = seq;
        tick(2);

        // 5: out_rdy low holds everything; start comes 2 cycles after raise
        out_rdy = 1'b0;
        clear_log();
        write_burst(40);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_val) seen++;
            @(posedge clk); #1;
        end
        check("t5_no_val", seen, 0);
        out_rdy = 1'b1;
        @(negedge clk);
        check("t5_c0_val", out_val, 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_c1_val", out_val, 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_c2_val", out_val, 1);
        check("t5_c2_sof", out_sof, 1);
        @(posedge clk); #1;
        wait_drain("t5_drain", 300);
        ack = seq;
        tick(2);

        // 6: en dropped mid-segment aborts without eof, resend from ack
        clear_log();
        s0 = seq;
        write_burst(40);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_val && !out_sof) && n < 200);
        en = 1'b0;
        @(negedge clk);
        check("t6_val_low", out_val, 0);
        check("t6_no_eof", out_eof, 0);
        check("t6_no_log", log_seq.size(), 0);
        @(posedge clk); #1;
        tick(1);
        en = 1'b1;
        wait_drain("t6_drain", 400);
        check("t6_nsegs", log_seq.size(), 3);
        if (log_seq.size() == 3) check("t6_restart_seq", log_seq[0], s0);
        ack = seq;
        tick(2);

        // Random bursts, occasional rebase to a random sequence number
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 4) == 0) rebase($urandom);
            write_burst($urandom_range(1, 40));
            wait_drain("rnd_drain", 600);
            ack = seq;
            tick($urandom_range(1, 6));
        end
        check("total_retrans", n_retrans, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
